// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: classifies ID-stage RAW hazards against EXE/MEM producers,
// drives stall/bubble/flush controls and keeps saturating stall and flush counters.
module hazard_ctl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_FwdEn,
   input  logic             id_Valid,
   input  logic [REG_W-1:0] id_Rs,
   input  logic [REG_W-1:0] id_Rt,
   input  logic             id_UsesRs,
   input  logic             id_UsesRt,
   input  logic             exe_Valid,
   input  logic             exe_RegWrite,
   input  logic [REG_W-1:0] exe_DstReg,
   input  logic [1:0]       exe_FwdStage,
   input  logic             exe_BranchTaken,
   input  logic             mem_RegWrite,
   input  logic [REG_W-1:0] mem_DstReg,
   output logic             pc_Stall,
   output logic             ifid_Stall,
   output logic             idex_Bubble,
   output logic             ifid_Flush,
   output logic             fwd_Enable,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushCount
);

   localparam logic [1:0] FWD_WB = 2'd2;

   typedef enum logic {RUN, STALL} state_t;

   state_t     state, next_state;
   logic [1:0] stall_left, next_left;
   logic       exe_match, mem_match, branch, hazard, long_stall;
   logic       stall, bubble, flush;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != '1)) ? v + 1'b1 : v;
   endfunction

   assign exe_match = id_Valid && exe_Valid && exe_RegWrite && (exe_DstReg != '0) &&
                      ((id_UsesRs && (id_Rs == exe_DstReg)) || (id_UsesRt && (id_Rt == exe_DstReg)));
   assign mem_match = id_Valid && mem_RegWrite && (mem_DstReg != '0) &&
                      ((id_UsesRs && (id_Rs == mem_DstReg)) || (id_UsesRt && (id_Rt == mem_DstReg)));
   assign branch    = exe_Valid && exe_BranchTaken;

   // Classification follows the latched mode so a mode change never splits a stall.
   assign hazard     = fwd_Enable ? (exe_match && (exe_FwdStage == FWD_WB))
                                  : (exe_match || mem_match);
   assign long_stall = !fwd_Enable && exe_match;

   always_comb begin
      next_state = state;
      next_left  = stall_left;
      stall      = 1'b0;
      bubble     = 1'b0;
      flush      = 1'b0;
      if (branch) begin
         flush      = 1'b1;
         bubble     = 1'b1;
         next_state = RUN;
         next_left  = 2'd0;
      end else begin
         case (state)
            RUN: begin
               if (hazard) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
                  if (long_stall) begin
                     next_state = STALL;
                     next_left  = 2'd1;
                  end
               end
            end
            STALL: begin
               stall  = 1'b1;
               bubble = 1'b1;
               if (stall_left <= 2'd1) begin
                  next_state = RUN;
                  next_left  = 2'd0;
               end else begin
                  next_left = stall_left - 2'd1;
               end
            end
            default: begin
               next_state = RUN;
               next_left  = 2'd0;
            end
         endcase
      end
      if (rst) begin
         stall  = 1'b0;
         bubble = 1'b0;
         flush  = 1'b0;
      end
   end

   assign pc_Stall    = stall;
   assign ifid_Stall  = stall;
   assign idex_Bubble = bubble;
   assign ifid_Flush  = flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         stall_left  <= 2'd0;
         fwd_Enable  <= 1'b1;
         stallCycles <= '0;
         flushCount  <= '0;
      end else begin
         state       <= next_state;
         stall_left  <= next_left;
         if ((state == RUN) && !stall)
            fwd_Enable <= cfg_FwdEn;
         stallCycles <= sat_inc(stallCycles, stall);
         flushCount  <= sat_inc(flushCount, flush);
      end
   end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 Parameter REG_W, default `FLD_REGNUM_SIZE (5), register-number width.
REQ-002 Parameter CNT_W, default 16, width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_FwdEn  input  1  forwarding mode request; 1 = forwarding, 0 = stall-only.
REQ-006 id_Valid  input  1  ID stage holds a real instruction.
REQ-007 id_Rs, id_Rt  input  REG_W each  ID source register numbers.
REQ-008 id_UsesRs, id_UsesRt  input  1 each  the corresponding ID source is actually read.
REQ-009 exe_Valid, exe_RegWrite  input  1 each  EXE holds a real instruction; it writes a register.
REQ-010 exe_DstReg  input  REG_W  EXE destination register.
REQ-011 exe_FwdStage  input  2  EXE forwarding flag (`RESULT_FWD_NONE/MEM/WB).
REQ-012 exe_BranchTaken  input  1  EXE resolved a taken branch this cycle.
REQ-013 mem_RegWrite  input  1  MEM instruction writes a register.
REQ-014 mem_DstReg  input  REG_W  MEM destination register.
REQ-015 pc_Stall, ifid_Stall  output  1 each  hold PC; hold IF/ID.
REQ-016 idex_Bubble  output  1  load a NOP into ID/EX.
REQ-017 ifid_Flush  output  1  clear IF/ID.
REQ-018 fwd_Enable  output  1  registered enable for the forwarding unit.
REQ-019 stallCycles, flushCount  output  CNT_W each  saturating performance counters.

Function
REQ-020 A source matches when id_Valid, the Uses bit, and producer RegWrite are all set, DstReg equals the source, and DstReg is nonzero; a producer in EXE additionally requires exe_Valid.
REQ-021 Forwarding mode: a hazard exists only on an EXE match with exe_FwdStage==`RESULT_FWD_WB (load-use); stall length is 1.
REQ-022 Stall-only mode: an EXE match gives stall length 2; otherwise a MEM match gives stall length 1; the longest match wins.
REQ-023 The FSM has two states, RUN and STALL, plus a counter stallLeft of 2 bits.
REQ-024 In RUN, when a hazard is present and exe_BranchTaken=0, the block asserts pc_Stall, ifid_Stall, and idex_Bubble combinationally in the same cycle.
REQ-025 In RUN, when the stall length is 2, the FSM moves to STALL with stallLeft=1; when the stall length is 1, it stays in RUN.
REQ-026 In STALL, the block asserts pc_Stall, ifid_Stall, and idex_Bubble, and returns to RUN on the next edge.
REQ-027 exe_BranchTaken=1 with exe_Valid=1 asserts ifid_Flush and idex_Bubble, and deasserts pc_Stall and ifid_Stall.
REQ-028 A taken branch takes priority over any hazard, and from STALL it aborts the stall and returns the FSM to RUN.
REQ-029 fwd_Enable loads cfg_FwdEn only on edges where the FSM is in RUN and no stall output is asserted; at all other edges it holds its value.
REQ-030 Hazard classification uses the registered fwd_Enable, not cfg_FwdEn.
REQ-031 stallCycles increments by 1 on every edge where pc_Stall=1, and saturates at all-ones.
REQ-032 flushCount increments by 1 on every edge where ifid_Flush=1, and saturates at all-ones.
REQ-033 All outputs are glitch-free functions of the registered state and current-cycle inputs, with no combinational loop through the pipeline registers.

Reset
REQ-034 While rst=1, the FSM is forced to RUN, stallLeft=0, fwd_Enable=1, and both counters=0.
REQ-035 While rst=1, pc_Stall, ifid_Stall, idex_Bubble, and ifid_Flush are forced to 0 regardless of the other inputs.
REQ-036 Assertion of rst in the middle of a stall abandons the stall immediately, with no pending stall cycle after release.

Verification
REQ-037 Forwarding mode, EXE lw to $8 (FwdStage=WB), ID add reading $8 -> exactly 1 cycle of pc_Stall/idex_Bubble, stallCycles=1.
REQ-038 Forwarding mode, EXE add to $8 (FwdStage=MEM), ID reading $8 -> no stall.
REQ-039 ID reading $0 while EXE writes $0 -> no stall.
REQ-040 cfg_FwdEn=0 (after one RUN edge), EXE writes $9, ID reads $9 -> stall asserted for 2 consecutive cycles, then released; stallCycles=2.
REQ-041 Stall-only mode, 2-cycle stall; exe_BranchTaken=1 in the STALL cycle -> ifid_Flush=1, pc_Stall=0, FSM in RUN next edge, flushCount=1.
REQ-042 Preload stallCycles to all-ones by a long stall sequence, then apply a further stall -> value stays all-ones.
REQ-043 rst=1 pulse during STALL -> all stall outputs 0 within the same cycle, counters 0, fwd_Enable=1.
